// File: rtl/image_processing_accelerator_if.sv
// Bundle of the two slave input streams and the single master output stream
// of the image processing accelerator.
interface image_processing_accelerator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int COLOR_SIZE = 8
);
    logic [1:0]            slv0_mode;
    logic                  slv0_data_valid;
    logic [COLOR_SIZE-1:0] slv0_proc_val;
    logic [DATA_WIDTH-1:0] slv0_data;
    logic                  slv0_ready;

    logic [1:0]            slv1_mode;
    logic                  slv1_data_valid;
    logic [COLOR_SIZE-1:0] slv1_proc_val;
    logic [DATA_WIDTH-1:0] slv1_data;
    logic                  slv1_ready;

    logic                  mstr0_cmplt;
    logic                  mstr0_ready;
    logic [DATA_WIDTH-1:0] mstr0_data;
    logic [1:0]            mstr0_data_valid;

    // Accelerator side
    modport slave (
        input  slv0_mode, slv0_data_valid, slv0_proc_val, slv0_data,
        output slv0_ready,
        input  slv1_mode, slv1_data_valid, slv1_proc_val, slv1_data,
        output slv1_ready,
        output mstr0_cmplt, mstr0_data, mstr0_data_valid,
        input  mstr0_ready
    );

    // Environment side: drives the slave streams, consumes the output
    modport master (
        output slv0_mode, slv0_data_valid, slv0_proc_val, slv0_data,
        input  slv0_ready,
        output slv1_mode, slv1_data_valid, slv1_proc_val, slv1_data,
        input  slv1_ready,
        input  mstr0_cmplt, mstr0_data, mstr0_data_valid,
        output mstr0_ready
    );
endinterface

// File: rtl/image_processing_accelerator.sv
// Two-input round-robin pixel processor: per-channel pass/add/sub/threshold
// with a single output register (latency 1, one word per cycle).
module image_processing_accelerator #(
    parameter int DATA_WIDTH = 32,
    parameter int COLOR_SIZE = 8
) (
    input logic                          clk,
    input logic                          rst_n,
    image_processing_accelerator_if.slave bus
);
    localparam int NUM_CH = DATA_WIDTH / COLOR_SIZE;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_SUB  = 2'b10,
        MODE_THR  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_SLV0 = 2'b01,
        TAG_SLV1 = 2'b10
    } tag_e;

    tag_e                  out_tag;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  last_grant;

    logic                  out_free;
    logic                  grant;
    logic                  xfer0;
    logic                  xfer1;
    mode_e                 sel_mode;
    logic [COLOR_SIZE-1:0] sel_pv;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] next_data;

    function automatic logic [DATA_WIDTH-1:0] process_word(
        input mode_e                 mode,
        input logic [COLOR_SIZE-1:0] pv,
        input logic [DATA_WIDTH-1:0] word
    );
        logic [DATA_WIDTH-1:0] res;
        logic [COLOR_SIZE-1:0] ch;
        logic [COLOR_SIZE:0]   sum;
        res = '0;
        sum = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch = word[i*COLOR_SIZE +: COLOR_SIZE];
            case (mode)
                MODE_PASS: res[i*COLOR_SIZE +: COLOR_SIZE] = ch;
                MODE_ADD: begin
                    sum = {1'b0, ch} + {1'b0, pv};
                    res[i*COLOR_SIZE +: COLOR_SIZE] = sum[COLOR_SIZE] ? '1 : sum[COLOR_SIZE-1:0];
                end
                MODE_SUB:  res[i*COLOR_SIZE +: COLOR_SIZE] = (ch > pv) ? ch - pv : '0;
                MODE_THR:  res[i*COLOR_SIZE +: COLOR_SIZE] = (ch >= pv) ? '1 : '0;
            endcase
        end
        return res;
    endfunction

    // Grant: lone requester wins; on a tie the slave not served last wins;
    // with no requester slave 0 keeps the grant.
    always_comb begin
        out_free = (out_tag == TAG_NONE) || bus.mstr0_ready;
        grant    = 1'b0;
        if (bus.slv0_data_valid && bus.slv1_data_valid)
            grant = ~last_grant;
        else if (bus.slv1_data_valid)
            grant = 1'b1;
    end

    assign bus.slv0_ready  = !rst_n && out_free && !grant;
    assign bus.slv1_ready  = !rst_n && out_free &&  grant;
    assign bus.mstr0_cmplt = !rst_n && (out_tag != TAG_NONE) && bus.mstr0_ready;

    assign xfer0 = bus.slv0_ready && bus.slv0_data_valid;
    assign xfer1 = bus.slv1_ready && bus.slv1_data_valid;

    always_comb begin
        sel_mode = mode_e'(bus.slv0_mode);
        sel_pv   = bus.slv0_proc_val;
        sel_data = bus.slv0_data;
        if (grant) begin
            sel_mode = mode_e'(bus.slv1_mode);
            sel_pv   = bus.slv1_proc_val;
            sel_data = bus.slv1_data;
        end
        next_data = process_word(sel_mode, sel_pv, sel_data);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            out_tag    <= TAG_NONE;
            out_data   <= '0;
            last_grant <= 1'b1;
        end else if (xfer0) begin
            out_tag    <= TAG_SLV0;
            out_data   <= next_data;
            last_grant <= 1'b0;
        end else if (xfer1) begin
            out_tag    <= TAG_SLV1;
            out_data   <= next_data;
            last_grant <= 1'b1;
        end else if (bus.mstr0_ready) begin
            // Drained with nothing to refill: data holds its last value
            out_tag <= TAG_NONE;
        end
    end

    assign bus.mstr0_data       = out_data;
    assign bus.mstr0_data_valid = out_tag;
endmodule

// File: tb/tb_image_processing_accelerator.sv
// Directed self-checking bench for image_processing_accelerator.
module tb_image_processing_accelerator;
    logic clk;
    logic rst_n;
    int   tests;
    int   failures;

    image_processing_accelerator_if #(.DATA_WIDTH(32), .COLOR_SIZE(8)) bus ();

    image_processing_accelerator #(.DATA_WIDTH(32), .COLOR_SIZE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests    = 0;
        failures = 0;
        rst_n    = 1'b1;
        bus.slv0_mode = 2'b00; bus.slv0_data_valid = 1'b0; bus.slv0_proc_val = 8'h00; bus.slv0_data = 32'h0;
        bus.slv1_mode = 2'b00; bus.slv1_data_valid = 1'b0; bus.slv1_proc_val = 8'h00; bus.slv1_data = 32'h0;
        bus.mstr0_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_tag",   {30'd0, bus.mstr0_data_valid}, 32'h0);
        check("rst_data",  bus.mstr0_data, 32'h0);
        check("rst_rdy0",  {31'd0, bus.slv0_ready}, 32'h0);
        check("rst_rdy1",  {31'd0, bus.slv1_ready}, 32'h0);
        check("rst_cmplt", {31'd0, bus.mstr0_cmplt}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("idle_rdy0", {31'd0, bus.slv0_ready}, 32'h1);
        check("idle_rdy1", {31'd0, bus.slv1_ready}, 32'h0);

        // Pass-through from slave 0
        bus.slv0_data_valid = 1'b1; bus.slv0_mode = 2'b00; bus.slv0_data = 32'h11223344;
        tick();
        bus.slv0_data_valid = 1'b0;
        check("pass_data",  bus.mstr0_data, 32'h11223344);
        check("pass_tag",   {30'd0, bus.mstr0_data_valid}, 32'h1);
        check("pass_cmplt", {31'd0, bus.mstr0_cmplt}, 32'h1);

        // Saturating add from slave 1
        bus.slv1_data_valid = 1'b1; bus.slv1_mode = 2'b01; bus.slv1_proc_val = 8'h20; bus.slv1_data = 32'hF0E01000;
        #1;
        check("add_rdy1", {31'd0, bus.slv1_ready}, 32'h1);
        tick();
        bus.slv1_data_valid = 1'b0;
        check("add_data", bus.mstr0_data, 32'hFFFF3020);
        check("add_tag",  {30'd0, bus.mstr0_data_valid}, 32'h2);

        // Saturating subtract then threshold, back to back from slave 0
        bus.slv0_data_valid = 1'b1; bus.slv0_mode = 2'b10; bus.slv0_proc_val = 8'h50; bus.slv0_data = 32'h40608000;
        tick();
        bus.slv0_mode = 2'b11; bus.slv0_proc_val = 8'h80; bus.slv0_data = 32'h7F80FF00;
        check("sub_data", bus.mstr0_data, 32'h00103000);
        check("sub_tag",  {30'd0, bus.mstr0_data_valid}, 32'h1);
        tick();
        bus.slv0_data_valid = 1'b0;
        check("thr_data", bus.mstr0_data, 32'h00FFFF00);
        tick();
        check("drain_tag",  {30'd0, bus.mstr0_data_valid}, 32'h0);
        check("drain_hold", bus.mstr0_data, 32'h00FFFF00);

        // Round-robin with both slaves always valid, starting fresh from reset
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        bus.slv0_mode = 2'b00; bus.slv0_data = 32'hA0A0A0A0; bus.slv0_data_valid = 1'b1;
        bus.slv1_mode = 2'b00; bus.slv1_data = 32'hB0B0B0B0; bus.slv1_data_valid = 1'b1;
        #1;
        check("rr_first_rdy0", {31'd0, bus.slv0_ready}, 32'h1);
        check("rr_first_rdy1", {31'd0, bus.slv1_ready}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_tag",   {30'd0, bus.mstr0_data_valid}, (i % 2 == 0) ? 32'h1 : 32'h2);
            check("rr_data",  bus.mstr0_data, (i % 2 == 0) ? 32'hA0A0A0A0 : 32'hB0B0B0B0);
            check("rr_cmplt", {31'd0, bus.mstr0_cmplt}, 32'h1);
        end

        // Backpressure: word from slave 1 stalls for three cycles
        bus.mstr0_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_data",  bus.mstr0_data, 32'hB0B0B0B0);
            check("bp_tag",   {30'd0, bus.mstr0_data_valid}, 32'h2);
            check("bp_rdy",   {30'd0, bus.slv1_ready, bus.slv0_ready}, 32'h0);
            check("bp_cmplt", {31'd0, bus.mstr0_cmplt}, 32'h0);
            tick();
        end
        bus.mstr0_ready = 1'b1;
        #1;
        check("rel_cmplt", {31'd0, bus.mstr0_cmplt}, 32'h1);
        check("rel_rdy0",  {31'd0, bus.slv0_ready}, 32'h1);
        tick();
        check("rel_tag",  {30'd0, bus.mstr0_data_valid}, 32'h1);
        check("rel_data", bus.mstr0_data, 32'hA0A0A0A0);

        // Reset while a word is pending and stalled
        bus.mstr0_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        check("mid_rst_rdy",   {30'd0, bus.slv1_ready, bus.slv0_ready}, 32'h0);
        check("mid_rst_cmplt", {31'd0, bus.mstr0_cmplt}, 32'h0);
        tick();
        check("mid_rst_tag",  {30'd0, bus.mstr0_data_valid}, 32'h0);
        check("mid_rst_data", bus.mstr0_data, 32'h0);
        bus.mstr0_ready = 1'b1;
        #1;
        check("mid_rst_cmplt2", {31'd0, bus.mstr0_cmplt}, 32'h0);

        // Resume; add boundaries at exactly and just over full scale
        rst_n = 1'b0;
        bus.slv0_data_valid = 1'b0;
        bus.slv1_mode = 2'b01; bus.slv1_proc_val = 8'h01; bus.slv1_data = 32'hFE00FF7F;
        tick();
        bus.slv1_data_valid = 1'b0;
        check("add_edge_data", bus.mstr0_data, 32'hFF01FF80);
        check("add_edge_tag",  {30'd0, bus.mstr0_data_valid}, 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
